// File: rtl/symbol_fetch_if.sv
// Bus bundle for symbol_fetch: the FIFO read side and the symbol stream side.
// The master is the fetcher; the slave is the surrounding FIFO plus consumer.
interface symbol_fetch_if #(
    parameter int IN_W  = 32,
    parameter int SYM_W = 8
);
    logic [IN_W-1:0]  fifo_data;
    logic             fifo_empty;
    logic             fifo_r_en;
    logic [SYM_W-1:0] sym_out;
    logic             sym_valid;
    logic             sym_ready;

    modport master (
        input  fifo_data, fifo_empty, sym_ready,
        output fifo_r_en, sym_out, sym_valid
    );

    modport slave (
        output fifo_data, fifo_empty, sym_ready,
        input  fifo_r_en, sym_out, sym_valid
    );
endinterface

// File: rtl/symbol_fetch.sv
// Symbol fetcher: pops IN_W-bit words from a one-cycle-latency FIFO into a
// small prefetch buffer and hands them out as IN_W/SYM_W symbols through a
// valid/ready stream, counting symbols and flagging the end of each pass.
module symbol_fetch #(
    parameter int IN_W      = 32,
    parameter int SYM_W     = 8,
    parameter int DEPTH     = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           start,
    input  logic           done,
    symbol_fetch_if.master bus,
    output logic           pass_done,
    output logic           busy,
    output logic [31:0]    sym_count
);
    localparam int N     = IN_W / SYM_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    generate
        if ((IN_W % SYM_W) != 0 || IN_W < SYM_W) begin : g_bad_width
            $error("symbol_fetch: IN_W must be a non-zero multiple of SYM_W");
        end
        if (DEPTH < 1) begin : g_bad_depth
            $error("symbol_fetch: DEPTH must be at least 1");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state_q;
    logic               pending_q;     // a FIFO pop is in flight; data lands next edge
    logic [CNT_W-1:0]   buf_count_q;
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [IDX_W-1:0]   idx_q;         // next symbol of the head word to present
    logic [SYM_W-1:0]   sym_out_q;
    logic               sym_valid_q;
    logic               pass_done_q;
    logic [31:0]        sym_count_q;
    logic [IN_W-1:0]    buf_mem_q [DEPTH];

    logic               run;
    logic               fifo_r_en;
    logic               load_cond;
    logic               can_load;
    logic               last_sym;
    logic               pop;
    logic               end_pass;
    logic [IN_W-1:0]    head_word;
    logic [SYM_W-1:0]   head_sym;
    int                 shamt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Pop credit, load/pop decisions and head-symbol selection
    always_comb begin
        // NOTE: every always_comb output gets a value on every path so no latch is inferred.
        run       = (state_q == RUN);
        // Credit counts words in flight; a pop in this same cycle deliberately frees nothing.
        fifo_r_en = run && !bus.fifo_empty
                    && ((int'(buf_count_q) + int'(pending_q)) < DEPTH);
        load_cond = run && (!sym_valid_q || bus.sym_ready);
        can_load  = load_cond && (buf_count_q != '0);
        last_sym  = (int'(idx_q) == N - 1);
        pop       = can_load && last_sym;
        end_pass  = run && done && bus.fifo_empty && !pending_q
                    && (buf_count_q == '0) && (!sym_valid_q || bus.sym_ready);
        head_word = buf_mem_q[head_q];
        shamt     = (MSB_FIRST != 0) ? (N - 1 - int'(idx_q)) * SYM_W
                                     : int'(idx_q) * SYM_W;
        head_sym  = SYM_W'(head_word >> shamt);
    end

    // FSM, buffer bookkeeping, output register and symbol counter
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            buf_count_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            idx_q       <= '0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
            pass_done_q <= 1'b0;
            sym_count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
            pending_q   <= fifo_r_en;
            pass_done_q <= 1'b0;
            if (pending_q) begin
                tail_q <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q <= ptr_inc(head_q);
            end
            buf_count_q <= buf_count_q + CNT_W'(pending_q) - CNT_W'(pop);
            if (run && sym_valid_q && bus.sym_ready) begin
                sym_count_q <= sym_count_q + 32'd1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RUN;
                        sym_count_q <= '0;
                    end
                end
                RUN: begin
                    if (end_pass) begin
                        state_q     <= IDLE;
                        sym_valid_q <= 1'b0;
                        pass_done_q <= 1'b1;
                    end else if (can_load) begin
                        sym_out_q   <= head_sym;
                        sym_valid_q <= 1'b1;
                        idx_q       <= last_sym ? '0 : idx_q + 1'b1;
                    end else if (load_cond) begin
                        // Buffer ran dry: drop valid but stay in RUN waiting for data.
                        sym_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Capture the word popped last cycle into the buffer tail
    always_ff @(posedge clk) begin
        // NOTE: the word buffer is datapath only and is not reset; buf_count_q alone marks live entries.
        if (pending_q) begin
            buf_mem_q[tail_q] <= bus.fifo_data;
        end
    end

    assign bus.fifo_r_en = fifo_r_en;
    assign bus.sym_out   = sym_out_q;
    assign bus.sym_valid = sym_valid_q;
    assign pass_done     = pass_done_q;
    assign busy          = run;
    assign sym_count     = sym_count_q;

endmodule

// File: tb/tb_symbol_fetch.sv
// Directed bench for symbol_fetch: two instances (MSB-first and LSB-first)
// share one FIFO model and stimulus; expected symbols are hand-written tables.
module tb_symbol_fetch;
    localparam int IN_W  = 32;
    localparam int SYM_W = 8;
    localparam int DEPTH = 2;

    logic            clk       = 1'b0;
    logic            n_rst     = 1'b0;
    logic            start     = 1'b0;
    logic            done      = 1'b0;
    logic            sym_ready = 1'b0;
    logic [IN_W-1:0] fifo_data = '0;
    logic [IN_W-1:0] fifo_mem [32];
    int              wr_cnt    = 0;
    int              rd_ptr    = 0;
    logic            fifo_empty;

    logic            pd_a, busy_a, pd_b, busy_b;
    logic [31:0]     cnt_a, cnt_b;

    int              n_total    = 0;
    int              n_bad      = 0;
    int              pd_seen    = 0;
    int              depth_viol = 0;
    logic [7:0]      got_q [$];
    logic [7:0]      gotb_q [$];

    logic [7:0] exp_msb [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] exp_lsb [8] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
    logic [7:0] exp_und [8] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    bit         pat [6]     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    symbol_fetch_if #(.IN_W(IN_W), .SYM_W(SYM_W)) if_a ();
    symbol_fetch_if #(.IN_W(IN_W), .SYM_W(SYM_W)) if_b ();

    assign fifo_empty      = (rd_ptr >= wr_cnt);
    assign if_a.fifo_data  = fifo_data;
    assign if_a.fifo_empty = fifo_empty;
    assign if_a.sym_ready  = sym_ready;
    assign if_b.fifo_data  = fifo_data;
    assign if_b.fifo_empty = fifo_empty;
    assign if_b.sym_ready  = sym_ready;

    symbol_fetch #(.IN_W(IN_W), .SYM_W(SYM_W), .DEPTH(DEPTH), .MSB_FIRST(1)) dut_a (
        .clk(clk), .n_rst(n_rst), .start(start), .done(done), .bus(if_a),
        .pass_done(pd_a), .busy(busy_a), .sym_count(cnt_a)
    );

    symbol_fetch #(.IN_W(IN_W), .SYM_W(SYM_W), .DEPTH(DEPTH), .MSB_FIRST(0)) dut_b (
        .clk(clk), .n_rst(n_rst), .start(start), .done(done), .bus(if_b),
        .pass_done(pd_b), .busy(busy_b), .sym_count(cnt_b)
    );

    always #5 clk = ~clk;

    // FIFO with one-cycle read latency, popped by the MSB-first instance
    always @(posedge clk) begin
        if (if_a.fifo_r_en) begin
            fifo_data <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Pass-done pulse counter and buffer occupancy guard
    always @(negedge clk) begin
        if (pd_a) pd_seen++;
        if (int'(dut_a.buf_count_q) + int'(dut_a.pending_q) > DEPTH) depth_viol++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [IN_W-1:0] w);
        fifo_mem[wr_cnt] = w;
        wr_cnt++;
    endtask

    // Drive ready for the coming edge, record any symbol that edge accepts
    task automatic cycle(input logic rdy);
        sym_ready = rdy;
        if (if_a.sym_valid && rdy) got_q.push_back(if_a.sym_out);
        if (if_b.sym_valid && rdy) gotb_q.push_back(if_b.sym_out);
        tick();
    endtask

    task automatic run_to_pass_done(input int budget);
        int i;
        i = 0;
        while (!pd_a && i < budget) begin
            cycle(1'b1);
            i++;
        end
        check("pass_done_seen", 64'(pd_a), 64'd1);
    endtask

    int   n_cyc;
    int   pd_base;
    int   v_bad, b_bad, p_bad;
    logic stall_prev;
    logic [7:0] prev_sym;

    initial begin
        // ---- reset with random inputs ----
        for (int i = 0; i < 4; i++) begin
            start     = 1'($urandom);
            done      = 1'($urandom);
            sym_ready = 1'($urandom);
            tick();
            check("rst_outputs",
                  {if_a.fifo_r_en, if_a.sym_valid, if_a.sym_out, pd_a, busy_a, cnt_a},
                  64'd0);
        end
        start = 1'b0; done = 1'b0; sym_ready = 1'b0;
        push(32'hAABBCCDD);
        push(32'h11223344);
        n_rst = 1'b1;
        v_bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (if_a.fifo_r_en || busy_a) v_bad++;
        end
        check("idle_no_ren", 64'(v_bad), 64'd0);

        // ---- basic pass, both symbol orders ----
        pd_base = pd_seen;
        got_q.delete(); gotb_q.delete();
        done = 1'b1; sym_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ren", {if_a.fifo_r_en, busy_a}, 64'b11);
        tick();
        check("lat_e1_valid", 64'(if_a.sym_valid), 64'd0);
        tick();
        check("lat_e2_valid", 64'(if_a.sym_valid), 64'd0);
        tick();
        check("lat_e3_valid", 64'(if_a.sym_valid), 64'd1);
        n_cyc = 0;
        while (!pd_a && n_cyc < 20) begin
            cycle(1'b1);
            n_cyc++;
        end
        check("basic_no_bubble", 64'(n_cyc), 64'd8);
        check("basic_pd_busy", {pd_a, busy_a, if_a.sym_valid}, 64'b100);
        check("basic_count", 64'(cnt_a), 64'd8);
        check("basic_nsym", 64'(got_q.size()), 64'd8);
        check("lsb_nsym", 64'(gotb_q.size()), 64'd8);
        for (int k = 0; k < 8 && k < got_q.size(); k++) check("basic_sym", 64'(got_q[k]), 64'(exp_msb[k]));
        for (int k = 0; k < 8 && k < gotb_q.size(); k++) check("lsb_sym", 64'(gotb_q[k]), 64'(exp_lsb[k]));
        tick();
        check("pd_one_cycle", 64'(pd_a), 64'd0);
        check("basic_pd_pulses", 64'(pd_seen - pd_base), 64'd1);

        // ---- backpressure ----
        got_q.delete(); gotb_q.delete();
        push(32'h01020304); push(32'h05060708); push(32'h090A0B0C); push(32'h0D0E0F10);
        start = 1'b1;
        cycle(pat[0]);
        start = 1'b0;
        stall_prev = 1'b0;
        prev_sym   = '0;
        n_cyc      = 1;
        while (!pd_a && n_cyc < 200) begin
            if (stall_prev) check("stall_hold", {if_a.sym_valid, if_a.sym_out}, {1'b1, prev_sym});
            stall_prev = if_a.sym_valid && !pat[n_cyc % 6];
            prev_sym   = if_a.sym_out;
            cycle(pat[n_cyc % 6]);
            n_cyc++;
        end
        check("bp_pass_done", 64'(pd_a), 64'd1);
        check("bp_nsym", 64'(got_q.size()), 64'd16);
        for (int k = 0; k < 16 && k < got_q.size(); k++) check("bp_sym", 64'(got_q[k]), 64'(k + 1));
        check("bp_count", 64'(cnt_a), 64'd16);
        check("bp_depth", 64'(depth_viol), 64'd0);

        // ---- underrun ----
        tick();
        got_q.delete(); gotb_q.delete();
        done = 1'b0;
        push(32'hA1A2A3A4);
        start = 1'b1;
        cycle(1'b1);
        start = 1'b0;
        n_cyc = 0;
        while (got_q.size() < 4 && n_cyc < 30) begin
            cycle(1'b1);
            n_cyc++;
        end
        check("und_first_word", 64'(got_q.size()), 64'd4);
        v_bad = 0; b_bad = 0; p_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (if_a.sym_valid) v_bad++;
            if (!busy_a) b_bad++;
            if (pd_a) p_bad++;
            cycle(1'b1);
        end
        check("und_gap_valid", 64'(v_bad), 64'd0);
        check("und_gap_busy", 64'(b_bad), 64'd0);
        check("und_gap_pd", 64'(p_bad), 64'd0);
        push(32'hB1B2B3B4);
        done = 1'b1;
        run_to_pass_done(30);
        check("und_nsym_at_pd", 64'(got_q.size()), 64'd8);
        for (int k = 0; k < 8 && k < got_q.size(); k++) check("und_sym", 64'(got_q[k]), 64'(exp_und[k]));
        check("und_count", 64'(cnt_a), 64'd8);

        // ---- async reset mid-stream, then restart ----
        tick();
        got_q.delete(); gotb_q.delete();
        push(32'hC1C2C3C4); push(32'hC5C6C7C8);
        start = 1'b1;
        cycle(1'b1);
        start = 1'b0;
        n_cyc = 0;
        while (got_q.size() < 3 && n_cyc < 30) begin
            cycle(1'b1);
            n_cyc++;
        end
        check("ar_pre_state", {if_a.sym_valid, busy_a, cnt_a}, {2'b11, 32'd3});
        #2;
        n_rst = 1'b0;
        #1;
        check("ar_outputs",
              {if_a.fifo_r_en, if_a.sym_valid, if_a.sym_out, pd_a, busy_a, cnt_a},
              64'd0);
        tick();
        n_rst = 1'b1;
        tick();
        got_q.delete(); gotb_q.delete();
        push(32'hE1E2E3E4);
        start = 1'b1;
        cycle(1'b1);
        start = 1'b0;
        check("ar_restart_count", 64'(cnt_a), 64'd0);
        run_to_pass_done(30);
        check("ar_nsym", 64'(got_q.size()), 64'd4);
        if (got_q.size() > 0) check("ar_first_sym", 64'(got_q[0]), 64'hE1);
        check("ar_count", 64'(cnt_a), 64'd4);
        tick();
        check("total_pd_pulses", 64'(pd_seen - pd_base), 64'd4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/symbol_fetch.md
# symbol_fetch

Parametrised symbol fetcher for the Huffman encoding path. It pops IN_W-bit words from the upstream input FIFO using a one-cycle read latency. It unpacks each word into IN_W/SYM_W symbols of SYM_W bits and presents them to the dictionary/encoder through a valid/ready handshake, with a small prefetch buffer so a ready consumer is not stalled. It also counts symbols per pass and signals end of pass once the producer's `done` is seen and all data has drained.

## Interface
- IN_W, 32, FIFO word width; must be a multiple of SYM_W (elaboration error otherwise)
- SYM_W, 8, symbol width
- DEPTH, 2, prefetch word-buffer entries, ≥1
- MSB_FIRST, 1, 1: symbol 0 = bits [IN_W-1 -: SYM_W]; 0: symbol 0 = bits [SYM_W-1:0]
- clk  in  1  clock, all state on rising edge
- n_rst  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a pass when in IDLE, ignored otherwise
- done  in  1  level; producer has written its final word to the FIFO
- fifo_data  in  IN_W  FIFO read data, valid the cycle after fifo_r_en
- fifo_empty  in  1  FIFO empty flag
- fifo_r_en  out  1  FIFO pop request
- sym_out  out  SYM_W  current symbol
- sym_valid  out  1  sym_out valid
- sym_ready  in  1  consumer accepts symbol
- pass_done  out  1  one-cycle pulse at end of pass
- busy  out  1  high in RUN
- sym_count  out  32  symbols handed over this pass

## Operation
- States: IDLE, RUN. Reset → IDLE.
- IDLE, start=1 → RUN. sym_count clears to 0 on the same edge.
- fifo_r_en = (state==RUN) && !fifo_empty && (buf_count + pending) < DEPTH.
  - pending = fifo_r_en registered from the previous cycle.
  - fifo_r_en never depends on sym_ready.
  - A buffer pop in the same cycle does not free credit.
- When pending=1, fifo_data is written into the buffer tail at that edge.
- An output register holds sym_out/sym_valid, plus symbol index idx (0..N-1, N=IN_W/SYM_W) into the head word.
- Load rule:
  - At an edge with (!sym_valid || sym_ready) and buf_count>0, load symbol idx of the head word and set sym_valid=1.
  - Then idx++. When idx==N-1 is loaded, idx→0 and the head word pops.
  - If the load condition holds but buf_count==0, sym_valid→0.
- sym_count increments on every sym_valid && sym_ready edge. It wraps at 2^32.
- End of pass: in RUN, when done && fifo_empty && !pending && buf_count==0 && (!sym_valid || sym_ready):
  - pass_done=1 for the next cycle.
  - State → IDLE and sym_valid → 0.
  - sym_count holds its value until the next start.
- done=1 while data remains: keep draining; no early termination.
- FIFO empty with done=0: sym_valid drops after the buffer drains; busy stays 1.
- n_rst low at any time: all state clears immediately. A word already popped but not yet captured is discarded.

## Timing
- Reset values: fifo_r_en=0, sym_out=0, sym_valid=0, pass_done=0, busy=0, sym_count=0, state IDLE, buf_count=0, idx=0.
- Start latency, with FIFO non-empty, measured from edge E0 that samples start:
  - fifo_r_en is high after E0.
  - The word is captured at E2.
  - sym_valid=1 after E3.
- Throughput:
  - With sym_ready held high, 1 symbol/cycle is sustained with no bubbles when DEPTH≥2 and N≥2.
  - With DEPTH=1, a bubble is permitted at word boundaries.
- sym_out and sym_valid are stable while sym_valid && !sym_ready.
- pass_done is high exactly one cycle after the edge accepting the final symbol.

## Test plan
- Reset: hold n_rst=0 with random inputs → all outputs 0. Release, no start → fifo_r_en stays 0.
- Default params, FIFO {0xAABBCCDD, 0x11223344}, done=1, sym_ready=1, pulse start → sym_valid 3 cycles after start edge; AA,BB,CC,DD,11,22,33,44 on consecutive cycles; pass_done pulses once; sym_count=8; busy falls with pass_done.
- Same data, MSB_FIRST=0 → DD,CC,BB,AA,44,33,22,11.
- Backpressure: sym_ready pattern 1,0,0,1,0,1… over 4 words → every symbol in order exactly once, sym_out stable while stalled, buf_count+pending never exceeds DEPTH.
- Underrun: one word, done=0, FIFO empty for 10 cycles, then second word and done=1 → sym_valid low during gap, busy=1, no pass_done until the 8th symbol is accepted.
- Async reset mid-stream after 3 symbols: n_rst low between edges → outputs clear without a clock edge. Restart with new data → first symbol from the new data, sym_count restarts at 0.
